// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control FSM for an RV32I datapath. Decodes the
//                instruction register, selects the immediate format, and
//                sequences FETCH/DECODE/EXEC/MEM/WB with the datapath strobes
//                and a retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int D_W   = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [D_W-1:0]   inst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             br_taken,
    output logic [2:0]       imm_sel,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             alu_out_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    // FSM state encoding
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    // Instruction class captured at DECODE; drives all later-state decisions
    localparam logic [3:0] C_R      = 4'd0;
    localparam logic [3:0] C_IALU   = 4'd1;
    localparam logic [3:0] C_LOAD   = 4'd2;
    localparam logic [3:0] C_STORE  = 4'd3;
    localparam logic [3:0] C_BRANCH = 4'd4;
    localparam logic [3:0] C_JALR   = 4'd5;
    localparam logic [3:0] C_JAL    = 4'd6;
    localparam logic [3:0] C_LUI    = 4'd7;
    localparam logic [3:0] C_AUIPC  = 4'd8;

    logic [2:0]       state_q, state_d;
    logic [3:0]       class_q;
    logic [2:0]       imm_sel_q;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;

    logic             dec_legal;
    logic [3:0]       dec_class;
    logic [2:0]       dec_imm;
    logic             retire;
    logic             is_jump;
    logic             rd_nonzero;

    // Only opcode and rd fields are consumed here; the rest belongs to the datapath
    logic             unused_inst_bits;
    assign unused_inst_bits = ^inst[D_W-1:12];

    assign is_jump    = (class_q == C_JAL) || (class_q == C_JALR);
    assign rd_nonzero = |inst[11:7];

    assign imm_sel = imm_sel_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

    // Opcode decode: class and immediate format for the current IR contents
    always_comb begin
        dec_legal = 1'b1;
        dec_class = C_R;
        dec_imm   = imm_sel_q;
        case (inst[6:0])
            7'b0110011: begin dec_class = C_R;      dec_imm = 3'b011; end
            7'b0010011: begin dec_class = C_IALU;   dec_imm = 3'b000; end
            7'b0000011: begin dec_class = C_LOAD;   dec_imm = 3'b001; end
            7'b1100111: begin dec_class = C_JALR;   dec_imm = 3'b110; end
            7'b0100011: begin dec_class = C_STORE;  dec_imm = 3'b010; end
            7'b1100011: begin dec_class = C_BRANCH; dec_imm = 3'b100; end
            7'b0110111: begin dec_class = C_LUI;    dec_imm = 3'b101; end
            7'b0010111: begin dec_class = C_AUIPC;  dec_imm = 3'b101; end
            7'b1101111: begin dec_class = C_JAL;    dec_imm = 3'b111; end
            default:    dec_legal = 1'b0;
        endcase
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (class_q == C_BRANCH)
                    state_d = S_FETCH;
                else if ((class_q == C_LOAD) || (class_q == C_STORE))
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ack)
                    state_d = (class_q == C_STORE) ? S_FETCH : S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath strobes; everything is held low while reset is asserted
    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        alu_out_we = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 2'b00;
        retire     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_EXEC: begin
                    alu_out_we = 1'b1;
                    alu_a_sel  = (class_q == C_AUIPC) || (class_q == C_JAL) ||
                                 (class_q == C_BRANCH);
                    alu_b_sel  = (class_q != C_R);
                    if (class_q == C_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (class_q == C_STORE);
                    if (dmem_ack && (class_q == C_STORE)) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we  = rd_nonzero;
                    wb_sel = (class_q == C_LOAD) ? 2'b01 :
                             is_jump             ? 2'b10 : 2'b00;
                    pc_we  = 1'b1;
                    pc_sel = is_jump;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, decoded class/immediate, sticky illegal flag and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= C_R;
            imm_sel_q <= 3'b000;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                if (dec_legal) begin
                    class_q   <= dec_class;
                    imm_sel_q <= dec_imm;
                end else begin
                    illegal_q <= 1'b1;
                end
            end
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl with a per-opcode
//                behavioural model of latency, strobes and retire count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic        imem_ack, dmem_ack, br_taken;

    logic [2:0]  imm_sel;
    logic        imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, alu_out_we;
    logic        dmem_req, dmem_we, rf_we, illegal;
    logic [1:0]  wb_sel;
    logic [31:0] instret;

    // Second copy with a narrow counter to exercise wrap-around
    logic [2:0]  imm_sel_n;
    logic        imem_req_n, ir_we_n, pc_we_n, pc_sel_n, alu_a_sel_n, alu_b_sel_n;
    logic        alu_out_we_n, dmem_req_n, dmem_we_n, rf_we_n, illegal_n;
    logic [1:0]  wb_sel_n;
    logic [2:0]  instret_n;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = '0;
    bit          all_ack  = 1'b0;

    wire [11:0] strobes = {imem_req, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                           alu_out_we, dmem_req, dmem_we, rf_we, wb_sel};

    always #5 clk = ~clk;

    multicycle_ctrl #(.D_W(32), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .inst(inst), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .br_taken(br_taken), .imm_sel(imm_sel),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_out_we(alu_out_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
        .illegal(illegal), .instret(instret)
    );

    multicycle_ctrl #(.D_W(32), .CNT_W(3)) u_dut_narrow (
        .clk(clk), .reset(reset), .inst(inst), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .br_taken(br_taken), .imm_sel(imm_sel_n),
        .imem_req(imem_req_n), .ir_we(ir_we_n), .pc_we(pc_we_n), .pc_sel(pc_sel_n),
        .alu_a_sel(alu_a_sel_n), .alu_b_sel(alu_b_sel_n), .alu_out_we(alu_out_we_n),
        .dmem_req(dmem_req_n), .dmem_we(dmem_we_n), .rf_we(rf_we_n), .wb_sel(wb_sel_n),
        .illegal(illegal_n), .instret(instret_n)
    );

    // Expected architectural behaviour of one legal instruction
    typedef struct {
        bit       legal;
        bit [2:0] isel;
        int       base;
        bit       mem;
        bit       store;
        bit       wr;
        bit [1:0] wb;
        bit       jump;
        bit       branch;
        bit       a;
        bit       b;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        e = '{legal: 1'b1, isel: 3'd0, base: 4, mem: 1'b0, store: 1'b0, wr: 1'b1,
              wb: 2'd0, jump: 1'b0, branch: 1'b0, a: 1'b0, b: 1'b1};
        case (ins[6:0])
            7'b0110011: begin e.isel = 3'b011; e.b = 1'b0; end
            7'b0010011: e.isel = 3'b000;
            7'b0000011: begin e.isel = 3'b001; e.base = 5; e.mem = 1'b1; e.wb = 2'b01; end
            7'b1100111: begin e.isel = 3'b110; e.wb = 2'b10; e.jump = 1'b1; end
            7'b0100011: begin e.isel = 3'b010; e.mem = 1'b1; e.store = 1'b1; e.wr = 1'b0; end
            7'b1100011: begin e.isel = 3'b100; e.base = 3; e.branch = 1'b1; e.wr = 1'b0; e.a = 1'b1; end
            7'b0110111: e.isel = 3'b101;
            7'b0010111: begin e.isel = 3'b101; e.a = 1'b1; end
            7'b1101111: begin e.isel = 3'b111; e.wb = 2'b10; e.jump = 1'b1; e.a = 1'b1; end
            default:    e.legal = 1'b0;
        endcase
        return e;
    endfunction

    // One reset cycle with random acks; strobes must be low throughout
    task automatic apply_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        imem_ack = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        #1;
        n_checks++;
        if (strobes !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %03h expected 000", strobes);
        end
        exp_cnt = '0;
    endtask

    // Runs one legal instruction from FETCH entry to retirement
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic br);
        exp_t e;
        int   cyc = 0, fc = 0, dc = 0;
        int   n_ir = 0, n_rf = 0, n_dr = 0, n_dw = 0, n_alu = 0;
        logic pcs = 1'b0, as = 1'b0, bs = 1'b0;
        logic [1:0] wbs = 2'b00;
        bit   done = 1'b0;
        e    = model(ins);
        inst = ins;
        for (int c = 0; c < 80 && !done; c++) begin
            @(posedge clk); #1;
            reset    = 1'b0;
            br_taken = br;
            if (imem_req) begin imem_ack = (fc >= iw); fc++; end
            else imem_ack = all_ack ? 1'b1 : 1'($urandom_range(0, 1));
            if (dmem_req) begin dmem_ack = (dc >= dw); dc++; end
            else dmem_ack = all_ack ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (c == 0) begin
                n_checks++;
                if (instret !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL instret: got %0d expected %0d", instret, exp_cnt);
                end
                n_checks++;
                if (instret_n !== exp_cnt[2:0]) begin
                    n_fail++;
                    $display("FAIL instret_wrap: got %0d expected %0d", instret_n, exp_cnt[2:0]);
                end
            end
            if (ir_we) n_ir++;
            if (rf_we) begin n_rf++; wbs = wb_sel; end
            if (dmem_req) n_dr++;
            if (dmem_we) n_dw++;
            if (alu_out_we) begin n_alu++; as = alu_a_sel; bs = alu_b_sel; end
            if (pc_we) begin pcs = pc_sel; done = 1'b1; end
        end
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: inst %08h never retired within 80 cycles", ins);
        end
        n_checks++;
        if (cyc != e.base + iw + (e.mem ? dw : 0)) begin
            n_fail++;
            $display("FAIL latency: inst %08h got %0d expected %0d", ins, cyc, e.base + iw + (e.mem ? dw : 0));
        end
        n_checks++;
        if (n_ir != 1 || n_alu != 1) begin
            n_fail++;
            $display("FAIL ir_alu_count: inst %08h got ir=%0d alu=%0d expected 1/1", ins, n_ir, n_alu);
        end
        n_checks++;
        if (as !== e.a || bs !== e.b) begin
            n_fail++;
            $display("FAIL alu_mux: inst %08h got a=%0b b=%0b expected a=%0b b=%0b", ins, as, bs, e.a, e.b);
        end
        n_checks++;
        if (n_rf != int'(e.wr && ins[11:7] != 5'd0)) begin
            n_fail++;
            $display("FAIL rf_we: inst %08h got %0d writes expected %0d", ins, n_rf, int'(e.wr && ins[11:7] != 5'd0));
        end
        if (n_rf > 0) begin
            n_checks++;
            if (wbs !== e.wb) begin
                n_fail++;
                $display("FAIL wb_sel: inst %08h got %0d expected %0d", ins, wbs, e.wb);
            end
        end
        n_checks++;
        if (pcs !== (e.branch ? br : e.jump)) begin
            n_fail++;
            $display("FAIL pc_sel: inst %08h got %0b expected %0b", ins, pcs, e.branch ? br : e.jump);
        end
        n_checks++;
        if (n_dr != (e.mem ? dw + 1 : 0) || n_dw != (e.store ? dw + 1 : 0)) begin
            n_fail++;
            $display("FAIL dmem: inst %08h got req=%0d we=%0d expected req=%0d we=%0d",
                     ins, n_dr, n_dw, e.mem ? dw + 1 : 0, e.store ? dw + 1 : 0);
        end
        n_checks++;
        if (imm_sel !== e.isel || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_sel: inst %08h got %0b ill=%0b expected %0b ill=0", ins, imm_sel, illegal, e.isel);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk); #1;
        reset    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || instret !== 32'd0 || instret_n !== 3'd0 ||
            illegal !== 1'b0 || imm_sel !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset: got req=%0b cnt=%0d ill=%0b imm=%0b expected 1/0/0/000",
                     imem_req, instret, illegal, imm_sel);
        end
    endtask

    task automatic test_directed();
        run_instr(32'h00500093, 0, 0, 1'b0);   // ADDI x1,x0,5
        run_instr(32'h0020A423, 0, 3, 1'b0);   // SW x2,8(x1), ack 3 cycles late
        run_instr(32'h00000463, 0, 0, 1'b1);   // BEQ taken
        run_instr(32'h00000463, 1, 0, 1'b0);   // BEQ not taken
        run_instr(32'h0080006F, 0, 0, 1'b0);   // JAL x0
        run_instr(32'h008000EF, 2, 0, 1'b0);   // JAL x1
        run_instr(32'h00008067, 0, 0, 1'b0);   // JALR x0,0(x1)
        run_instr(32'h0040A183, 1, 2, 1'b0);   // LW x3,4(x1)
        run_instr(32'h002081B3, 0, 0, 1'b0);   // ADD x3,x1,x2
        run_instr(32'h123452B7, 0, 0, 1'b0);   // LUI x5
        run_instr(32'h00001297, 0, 0, 1'b0);   // AUIPC x5
    endtask

    task automatic test_illegal();
        logic [31:0] held;
        held = exp_cnt;
        inst = 32'h0000007F;
        @(posedge clk); #1;
        reset = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_fetch: got imem_req=%0b expected 1", imem_req);
        end
        @(posedge clk); #1;
        imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            br_taken = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (illegal !== 1'b1 || strobes !== 12'd0 || instret !== held) begin
                n_fail++;
                $display("FAIL trap_hold: cycle %0d got ill=%0b strb=%03h cnt=%0d expected 1/000/%0d",
                         c, illegal, strobes, instret, held);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        int dm = 0;
        inst = 32'h00502283;                   // LW x5,5(x0)
        for (int c = 0; c < 20 && dm < 2; c++) begin
            @(posedge clk); #1;
            reset = 1'b0; imem_ack = imem_req; dmem_ack = 1'b0;
            #1;
            if (dmem_req) dm++;
        end
        n_checks++;
        if (dm < 2) begin
            n_fail++;
            $display("FAIL mem_reach: got %0d dmem_req cycles expected 2", dm);
        end
        @(posedge clk); #1;
        reset = 1'b1; dmem_ack = 1'b1; imem_ack = 1'b0;
        #1;
        n_checks++;
        if (strobes !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_mem_reset_strobes: got %03h expected 000", strobes);
        end
        @(posedge clk); #1;
        reset = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b0;
        #1;
        exp_cnt = '0;
        n_checks++;
        if (imem_req !== 1'b1 || rf_we !== 1'b0 || instret !== 32'd0 || instret_n !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_mem_reset: got req=%0b rf_we=%0b cnt=%0d expected 1/0/0",
                     imem_req, rf_we, instret);
        end
    endtask

    task automatic test_instret_wrap();
        for (int i = 0; i < 9; i++)
            run_instr(32'h00100093 | (32'(i) << 20), 0, 0, 1'b0);
        run_instr(32'h00000013, 0, 0, 1'b0);   // first-cycle check sees 9 / wrapped 1
    endtask

    task automatic test_random(input int n, input bit acks_high);
        logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        logic [31:0] ins;
        all_ack = acks_high;
        for (int i = 0; i < n; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            if (acks_high)
                run_instr(ins, 0, 0, 1'($urandom_range(0, 1)));
            else
                run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        all_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; inst = '0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_reset();
        test_directed();
        test_reset_mid_mem();
        test_instret_wrap();
        test_random(20, 1'b1);
        test_random(40, 1'b0);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (instret !== exp_cnt || instret_n !== exp_cnt[2:0]) begin
            n_fail++;
            $display("FAIL final_instret: got %0d/%0d expected %0d/%0d",
                     instret, instret_n, exp_cnt, exp_cnt[2:0]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
